// File: rtl/di_reg_terminal_pkg.sv
// di_pkg: shared definitions for the di_reg_terminal register responder.
//   - transfer status codes returned on di_transfer_status
//   - FSM state encoding
//   - len_to_mask(): di_len byte count -> byte-lane write mask
// Optional feature macro used by the design: DI_REG_TERMINAL_TIMEOUT_EN.
package di_pkg;

  localparam logic [15:0] ST_OK       = 16'h0000;
  localparam logic [15:0] ST_BAD_ADDR = 16'h0001;
  localparam logic [15:0] ST_RO       = 16'h0002;
  localparam logic [15:0] ST_BAD_LEN  = 16'h0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RD,
    S_WAIT_WR,
    S_RDY_RD,
    S_RDY_WR
  } di_state_e;

  // A zero mask marks an illegal length; the caller turns that into ST_BAD_LEN.
  function automatic logic [3:0] len_to_mask(input logic [31:0] len);
    case (len)
      32'd1:   return 4'b0001;
      32'd2:   return 4'b0011;
      32'd4:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/di_reg_terminal_if.sv
// di_reg_terminal_if: device-interface (di_*) bus between the IO bridge
// (master) and a register terminal (slave).
//   master drives: terminal/register address, length, mode/request/accept
//                  strobes and write data
//   slave drives:  read/write ready, read data and transfer status
interface di_reg_terminal_if;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic [31:0] di_len;
  logic        di_read_mode;
  logic        di_read_req;
  logic        di_read;
  logic        di_read_rdy;
  logic [31:0] di_reg_datao;
  logic        di_write_mode;
  logic        di_write;
  logic        di_write_rdy;
  logic [31:0] di_reg_datai;
  logic [15:0] di_transfer_status;

  modport master (
    output di_term_addr, di_reg_addr, di_len, di_read_mode, di_read_req,
           di_read, di_write_mode, di_write, di_reg_datai,
    input  di_read_rdy, di_reg_datao, di_write_rdy, di_transfer_status
  );

  modport slave (
    input  di_term_addr, di_reg_addr, di_len, di_read_mode, di_read_req,
           di_read, di_write_mode, di_write, di_reg_datai,
    output di_read_rdy, di_reg_datao, di_write_rdy, di_transfer_status
  );
endinterface

// File: rtl/di_reg_terminal_wait_timer.sv
// di_wait_timer: loadable down-counter with a done flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   done       : counter has reached zero (it then holds at zero)
module di_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/di_reg_terminal.sv
// di_reg_terminal: register-bank responder at one terminal address on the
// di_* bus. Serves single-word reads/writes with programmable wait states
// and returns a 16-bit transfer status per transaction.
//   ifclk, resetb : clock, asynchronous active-low reset
//   bus           : di_* bus, slave side
//   reg_q         : stored registers, lane i = [32i+31:32i] (RO lanes read 0)
//   ro_d          : read values for read-only registers
//   reg_wr_stb    : one-cycle strobe after a committed write
//   reg_rd_stb    : one-cycle strobe after an accepted read
// Optional feature: define DI_REG_TERMINAL_TIMEOUT_EN to drop an unaccepted
// ready after TIMEOUT_CYCLES and report it in status bit 15 (sticky).
module di_reg_terminal
  import di_pkg::*;
#(
  parameter logic [15:0]          TERM_ADDR      = 16'h0010,
  parameter int                   NUM_REGS       = 8,
  parameter int                   WAIT_STATES    = 2,
  parameter logic [NUM_REGS-1:0]  RO_MASK        = '0,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                     ifclk,
  input  logic                     resetb,
  di_reg_terminal_if.slave         bus,
  output logic [NUM_REGS*32-1:0]   reg_q,
  input  logic [NUM_REGS*32-1:0]   ro_d,
  output logic [NUM_REGS-1:0]      reg_wr_stb,
  output logic [NUM_REGS-1:0]      reg_rd_stb
);

  localparam int AW = $clog2(NUM_REGS);
`ifdef DI_REG_TERMINAL_TIMEOUT_EN
  localparam int TW = 16;
`else
  localparam int TW = 8;
`endif

  di_state_e           state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [3:0]          mask_q, mask_d;
  logic [15:0]         status_q, status_d;
  logic [31:0]         datao_q, datao_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
  logic [NUM_REGS-1:0] rd_stb_q, rd_stb_d;
  logic                wmode_q;
  logic                timeout_seen;
  logic                sticky_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_done;

  logic                sel;
  logic                addr_ok;
  logic [AW-1:0]       req_idx;
  logic [3:0]          req_mask;
  logic [15:0]         wr_code;
  logic [AW+4:0]       lane_base;
  logic [31:0]         rd_word;

  di_wait_timer #(.W(TW)) u_timer (
    .clk      (ifclk),
    .rst_n    (resetb),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign sel       = (bus.di_term_addr == TERM_ADDR);
  assign addr_ok   = (bus.di_reg_addr < 32'(NUM_REGS));
  assign req_idx   = bus.di_reg_addr[AW-1:0];
  assign req_mask  = len_to_mask(bus.di_len);
  assign lane_base = {idx_q, 5'b00000};

  // Write status priority: bad address, then read-only, then bad length.
  // Reads always return a full word, so only the address is checked there.
  always_comb begin
    wr_code = ST_OK;
    if (!addr_ok) begin
      wr_code = ST_BAD_ADDR;
    end else if (RO_MASK[req_idx]) begin
      wr_code = ST_RO;
    end else if (req_mask == 4'b0000) begin
      wr_code = ST_BAD_LEN;
    end
  end

  // Read data for the latched index; a bad address yields zero.
  always_comb begin
    rd_word = '0;
    if (status_q == ST_OK) begin
      rd_word = RO_MASK[idx_q] ? ro_d[lane_base +: 32] : regs_q[idx_q];
    end
  end

  // Transaction FSM, register merge and strobe generation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    status_d = status_q;
    datao_d  = datao_q;
    regs_d   = regs_q;
    wr_stb_d = '0;
    rd_stb_d = '0;
    sticky_d = timeout_seen;
    tmr_load = 1'b0;
    tmr_val  = TW'(WAIT_STATES);

    case (state_q)
      S_IDLE: begin
        if (sel && bus.di_read_req) begin
          state_d  = S_WAIT_RD;
          idx_d    = req_idx;
          status_d = addr_ok ? ST_OK : ST_BAD_ADDR;
          tmr_load = 1'b1;
        end else if (sel && bus.di_write_mode && !wmode_q) begin
          state_d  = S_WAIT_WR;
          idx_d    = req_idx;
          mask_d   = req_mask;
          status_d = wr_code;
          tmr_load = 1'b1;
        end
      end

      S_WAIT_RD: begin
        if (!bus.di_read_mode) begin
          state_d = S_IDLE;
        end else if (tmr_done) begin
          state_d  = S_RDY_RD;
          datao_d  = rd_word;
`ifdef DI_REG_TERMINAL_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end

      S_WAIT_WR: begin
        if (!bus.di_write_mode) begin
          state_d = S_IDLE;
        end else if (tmr_done) begin
          state_d  = S_RDY_WR;
`ifdef DI_REG_TERMINAL_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end

      S_RDY_RD: begin
        if (!bus.di_read_mode) begin
          state_d = S_IDLE;
        end else if (bus.di_read) begin
          state_d = S_IDLE;
          if (status_q == ST_OK) begin
            rd_stb_d[idx_q] = 1'b1;
          end
`ifdef DI_REG_TERMINAL_TIMEOUT_EN
        end else if (tmr_done) begin
          state_d  = S_IDLE;
          sticky_d = 1'b1;
`endif
        end
      end

      S_RDY_WR: begin
        if (!bus.di_write_mode) begin
          state_d = S_IDLE;
        end else if (bus.di_write) begin
          state_d = S_IDLE;
          if (status_q == ST_OK) begin
            for (int b = 0; b < 4; b++) begin
              if (mask_q[b]) begin
                regs_d[idx_q][b*8 +: 8] = bus.di_reg_datai[b*8 +: 8];
              end
            end
            wr_stb_d[idx_q] = 1'b1;
            if (idx_q == '0) begin
              sticky_d = 1'b0;
            end
          end
`ifdef DI_REG_TERMINAL_TIMEOUT_EN
        end else if (tmr_done) begin
          state_d  = S_IDLE;
          sticky_d = 1'b1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      status_q <= ST_OK;
      datao_q  <= '0;
      regs_q   <= '{default: '0};
      wr_stb_q <= '0;
      rd_stb_q <= '0;
      wmode_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      status_q <= status_d;
      datao_q  <= datao_d;
      regs_q   <= regs_d;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
      wmode_q  <= bus.di_write_mode;
    end
  end

`ifdef DI_REG_TERMINAL_TIMEOUT_EN
  logic sticky_q;
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
  assign timeout_seen = sticky_q;
`else
  assign timeout_seen = 1'b0;
`endif

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_lanes
    assign reg_q[i*32 +: 32] = regs_q[i];
  end

  assign bus.di_read_rdy        = (state_q == S_RDY_RD);
  assign bus.di_write_rdy       = (state_q == S_RDY_WR);
  assign bus.di_reg_datao       = datao_q;
  assign bus.di_transfer_status = {status_q[15] | timeout_seen, status_q[14:0]};
  assign reg_wr_stb             = wr_stb_q;
  assign reg_rd_stb             = rd_stb_q;

endmodule

// File: tb/tb_di_reg_terminal.sv
// tb_di_reg_terminal: table-driven check of di_reg_terminal with
// NUM_REGS=8, WAIT_STATES=2, register 5 read-only, TIMEOUT_CYCLES=16.
// Hand-written sequences cover reset, unselected traffic, aborts,
// reset during a transaction and (with DI_REG_TERMINAL_TIMEOUT_EN) timeout.
module tb_di_reg_terminal;

  localparam int          NREG = 8;
  localparam int          WS   = 2;
  localparam logic [15:0] TERM = 16'h0010;
  localparam logic [31:0] RO5  = 32'hCAFE_F00D;

  logic              ifclk;
  logic              resetb;
  logic [NREG*32-1:0] reg_q;
  logic [NREG*32-1:0] ro_d;
  logic [NREG-1:0]   reg_wr_stb;
  logic [NREG-1:0]   reg_rd_stb;

  di_reg_terminal_if bus();

  di_reg_terminal #(
    .TERM_ADDR      (TERM),
    .NUM_REGS       (NREG),
    .WAIT_STATES    (WS),
    .RO_MASK        (8'h20),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ifclk      (ifclk),
    .resetb     (resetb),
    .bus        (bus),
    .reg_q      (reg_q),
    .ro_d       (ro_d),
    .reg_wr_stb (reg_wr_stb),
    .reg_rd_stb (reg_rd_stb)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  typedef struct {
    bit          is_wr;
    logic [15:0] term;
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] wdata;
    int          lane;
    logic [31:0] exp_val;
    logic [15:0] exp_status;
    logic [7:0]  exp_stb;
    bit          exp_rdy;
  } vec_t;

  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(bit w, logic [15:0] t, logic [31:0] a, logic [31:0] l,
                              logic [31:0] d, int ln, logic [31:0] ev, logic [15:0] es,
                              logic [7:0] stb, bit rdy);
    vec_t v;
    v.is_wr = w; v.term = t; v.addr = a; v.len = l; v.wdata = d; v.lane = ln;
    v.exp_val = ev; v.exp_status = es; v.exp_stb = stb; v.exp_rdy = rdy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idleBus();
    bus.di_read_mode = 1'b0; bus.di_read_req = 1'b0; bus.di_read = 1'b0;
    bus.di_write_mode = 1'b0; bus.di_write = 1'b0;
  endtask

  // Start a transaction and wait (bounded) for ready; returns latency in cycles.
  task automatic startAndWait(input vec_t v, input int bound, output bit seen, output int lat);
    @(negedge ifclk);
    bus.di_term_addr = v.term; bus.di_reg_addr = v.addr;
    bus.di_len = v.len;        bus.di_reg_datai = v.wdata;
    if (v.is_wr) bus.di_write_mode = 1'b1;
    else begin bus.di_read_mode = 1'b1; bus.di_read_req = 1'b1; end
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= bound && !seen; i++) begin
      @(negedge ifclk);
      bus.di_read_req = 1'b0;
      if (bus.di_read_rdy || bus.di_write_rdy) begin seen = 1'b1; lat = i; end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    bit seen; int lat;
    logic [15:0] exp16;
    exp16 = v.is_wr ? {v.exp_stb, 8'h00} : {8'h00, v.exp_stb};
    startAndWait(v, v.exp_rdy ? 20 : 10, seen, lat);
    checkOutput({tag, ".rdy"}, 32'(seen), 32'(v.exp_rdy));
    if (seen) begin
      checkOutput({tag, ".rdy_kind"}, 32'(v.is_wr ? bus.di_write_rdy : bus.di_read_rdy), 32'd1);
      checkOutput({tag, ".latency"}, 32'(lat), 32'(WS + 2));
      checkOutput({tag, ".status"}, 32'(bus.di_transfer_status), 32'(v.exp_status));
      if (!v.is_wr) checkOutput({tag, ".rdata"}, bus.di_reg_datao, v.exp_val);
      if (v.is_wr) bus.di_write = 1'b1; else bus.di_read = 1'b1;
      @(negedge ifclk);
      idleBus();
      checkOutput({tag, ".rdy_drop"}, 32'(bus.di_read_rdy | bus.di_write_rdy), 32'd0);
    end else begin
      idleBus();
      @(negedge ifclk);
    end
    checkOutput({tag, ".stb"}, 32'({reg_wr_stb, reg_rd_stb}), 32'(exp16));
    if (v.is_wr) checkOutput({tag, ".lane"}, reg_q[v.lane*32 +: 32], v.exp_val);
    @(negedge ifclk);
    checkOutput({tag, ".stb_clr"}, 32'({reg_wr_stb, reg_rd_stb}), 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    bit seen; int lat; int hold;
    ro_d = '0;
    ro_d[5*32 +: 32] = RO5;
    bus.di_term_addr = '0; bus.di_reg_addr = '0; bus.di_len = '0; bus.di_reg_datai = '0;
    idleBus();
    resetb = 1'b0;
    repeat (3) @(negedge ifclk);

    // Reset state
    checkOutput("reset.read_rdy",  32'(bus.di_read_rdy), 32'd0);
    checkOutput("reset.write_rdy", 32'(bus.di_write_rdy), 32'd0);
    checkOutput("reset.datao",     bus.di_reg_datao, 32'd0);
    checkOutput("reset.status",    32'(bus.di_transfer_status), 32'd0);
    checkOutput("reset.reg_q_zero", 32'(reg_q == '0), 32'd1);
    checkOutput("reset.stb",       32'({reg_wr_stb, reg_rd_stb}), 32'd0);
    resetb = 1'b1;

    // Unselected traffic leaves every output at its reset value
    applyStimulus(mk(1, 16'h0011, 32'd1, 32'd4, 32'hFFFF_FFFF, 1, 32'h0, 16'h0, 8'h00, 0), "unsel_wr");
    applyStimulus(mk(0, 16'h0011, 32'd1, 32'd4, 32'h0, 0, 32'h0, 16'h0, 8'h00, 0), "unsel_rd");
    checkOutput("unsel.datao",  bus.di_reg_datao, 32'd0);
    checkOutput("unsel.status", 32'(bus.di_transfer_status), 32'd0);
    checkOutput("unsel.reg_q_zero", 32'(reg_q == '0), 32'd1);

    //            wr term  addr   len    wdata          lane expected       status  stb    rdy
    vecs[0]  = mk(1, TERM, 32'd1, 32'd4, 32'h1234_5678, 1, 32'h1234_5678, 16'h0, 8'h02, 1);
    vecs[1]  = mk(0, TERM, 32'd1, 32'd4, 32'h0,         1, 32'h1234_5678, 16'h0, 8'h02, 1);
    vecs[2]  = mk(1, TERM, 32'd3, 32'd4, 32'h1111_2222, 3, 32'h1111_2222, 16'h0, 8'h08, 1);
    vecs[3]  = mk(1, TERM, 32'd3, 32'd2, 32'hAAAA_BBBB, 3, 32'h1111_BBBB, 16'h0, 8'h08, 1);
    vecs[4]  = mk(1, TERM, 32'd3, 32'd1, 32'h5555_66CC, 3, 32'h1111_BBCC, 16'h0, 8'h08, 1);
    vecs[5]  = mk(1, TERM, 32'd9, 32'd4, 32'hDEAD_BEEF, 1, 32'h1234_5678, 16'h1, 8'h00, 1);
    vecs[6]  = mk(0, TERM, 32'd9, 32'd4, 32'h0,         0, 32'h0,         16'h1, 8'h00, 1);
    vecs[7]  = mk(1, TERM, 32'd5, 32'd4, 32'h1357_9BDF, 5, 32'h0,         16'h2, 8'h00, 1);
    vecs[8]  = mk(0, TERM, 32'd5, 32'd4, 32'h0,         5, RO5,           16'h0, 8'h20, 1);
    vecs[9]  = mk(1, TERM, 32'd2, 32'd3, 32'hFFFF_FFFF, 2, 32'h0,         16'h3, 8'h00, 1);
    vecs[10] = mk(0, TERM, 32'd3, 32'd4, 32'h0,         3, 32'h1111_BBCC, 16'h0, 8'h08, 1);
    vecs[11] = mk(1, TERM, 32'd0, 32'd4, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5, 16'h0, 8'h01, 1);
    vecs[12] = mk(1, 16'h0011, 32'd0, 32'd4, 32'h0,    0, 32'hA5A5_A5A5, 16'h0, 8'h00, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Write aborted while ready: no strobe, register unchanged
    startAndWait(mk(1, TERM, 32'd2, 32'd4, 32'h5555_5555, 2, 0, 0, 0, 1), 20, seen, lat);
    checkOutput("abort_wr.rdy", 32'(bus.di_write_rdy), 32'd1);
    idleBus();
    @(negedge ifclk);
    checkOutput("abort_wr.rdy_drop", 32'(bus.di_write_rdy), 32'd0);
    checkOutput("abort_wr.stb", 32'(reg_wr_stb), 32'd0);
    checkOutput("abort_wr.lane", reg_q[2*32 +: 32], 32'd0);

    // Read aborted while ready: no strobe
    startAndWait(mk(0, TERM, 32'd1, 32'd4, 32'h0, 1, 0, 0, 0, 1), 20, seen, lat);
    checkOutput("abort_rd.rdy", 32'(bus.di_read_rdy), 32'd1);
    idleBus();
    @(negedge ifclk);
    checkOutput("abort_rd.rdy_drop", 32'(bus.di_read_rdy), 32'd0);
    checkOutput("abort_rd.stb", 32'(reg_rd_stb), 32'd0);

    // Reset arriving together with the write commit: nothing survives
    startAndWait(mk(1, TERM, 32'd4, 32'd4, 32'h7777_7777, 4, 0, 0, 0, 1), 20, seen, lat);
    checkOutput("midreset.rdy", 32'(bus.di_write_rdy), 32'd1);
    bus.di_write = 1'b1;
    resetb = 1'b0;
    @(negedge ifclk);
    checkOutput("midreset.reg_q_zero", 32'(reg_q == '0), 32'd1);
    checkOutput("midreset.rdy", 32'(bus.di_write_rdy), 32'd0);
    checkOutput("midreset.stb", 32'(reg_wr_stb), 32'd0);
    idleBus();
    resetb = 1'b1;
    @(negedge ifclk);

`ifdef DI_REG_TERMINAL_TIMEOUT_EN
    // Unaccepted read drops after 16 ready cycles and sets status bit 15
    startAndWait(mk(0, TERM, 32'd1, 32'd4, 32'h0, 1, 0, 0, 0, 1), 20, seen, lat);
    hold = seen ? 1 : 0;
    while (seen && bus.di_read_rdy && hold < 40) begin
      @(negedge ifclk);
      if (bus.di_read_rdy) hold++;
    end
    checkOutput("timeout.ready_cycles", 32'(hold), 32'd16);
    idleBus();
    applyStimulus(mk(0, TERM, 32'd1, 32'd4, 32'h0, 1, 32'h0, 16'h8000, 8'h02, 1), "timeout.next_rd");
    applyStimulus(mk(1, TERM, 32'd0, 32'd4, 32'h0000_0042, 0, 32'h0000_0042, 16'h8000, 8'h01, 1), "timeout.clr_wr");
    applyStimulus(mk(0, TERM, 32'd1, 32'd4, 32'h0, 1, 32'h0, 16'h0000, 8'h02, 1), "timeout.after_clr");
`else
    hold = 0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/di_reg_terminal.md
# di_reg_terminal

Register-bank responder on the device-interface (di_*) bus: the target end of the MicroBlaze IO-to-di bridge. It decodes one terminal address and serves single-word reads and writes of up to 32 bits, using the `di_read_rdy`/`di_write_rdy` handshake with programmable wait states. It returns a 16-bit transfer status per transaction. It sits beside the bridge in the `ifclk` domain and exposes its registers as flat vectors to the surrounding logic.

## Interface
Parameters:
- `TERM_ADDR`, 16'h0010: terminal address this block answers to.
- `NUM_REGS`, 8: number of 32-bit registers (2..64).
- `WAIT_STATES`, 2: cycles between request capture and ready (0..255).
- `RO_MASK`, 0: bit i set means register i is read-only and reads `ro_d` lane i.
- `TIMEOUT_CYCLES`, 1024: ready-hold limit; used only with the macro.

Ports:
- `ifclk` in 1: the block's single clock.
- `resetb` in 1: reset, asynchronous and active-low.
- `di_term_addr` in 16: terminal select.
- `di_reg_addr` in 32: register index.
- `di_len` in 32: byte count (1, 2, or 4).
- `di_read_mode` in 1: read transaction in progress.
- `di_read_req` in 1: one-cycle read request.
- `di_read` in 1: one-cycle read accept.
- `di_read_rdy` out 1: read data valid.
- `di_reg_datao` out 32: read data.
- `di_write_mode` in 1: write transaction in progress.
- `di_write` in 1: one-cycle write commit.
- `di_write_rdy` out 1: ready to accept write.
- `di_reg_datai` in 32: write data.
- `di_transfer_status` out 16: status of current transaction.
- `reg_q` out NUM_REGS*32: stored register contents; lane i is [32i+31:32i].
- `ro_d` in NUM_REGS*32: read values for read-only registers.
- `reg_wr_stb` out NUM_REGS: one-cycle strobe on committed write.
- `reg_rd_stb` out NUM_REGS: one-cycle strobe on accepted read, for pop/clear-on-read logic.

## Operation
- `sel` = (`di_term_addr` == `TERM_ADDR`). Unselected traffic is ignored; outputs stay idle.
- Status codes:
  - 0x0000: OK.
  - 0x0001: address ≥ NUM_REGS.
  - 0x0002: write to a read-only register.
  - 0x0003: `di_len` not in {1, 2, 4}.
- FSM states:
  - IDLE:
    - `sel & di_read_req` → WAIT_RD. Latch address and status.
    - Otherwise, `sel & rising(di_write_mode)` → WAIT_WR. Latch address, len, and status.
    - A read request has priority over a write in the same cycle.
  - WAIT_RD / WAIT_WR: count `WAIT_STATES` cycles, then go to RDY_RD / RDY_WR.
  - RDY_RD:
    - Hold `di_read_rdy`=1, `di_reg_datao`, and the status.
    - On `di_read`: pulse `reg_rd_stb[addr]` (only when status OK), then → IDLE.
  - RDY_WR:
    - Hold `di_write_rdy`=1.
    - On `di_write`, if status is OK:
      - Merge `di_reg_datai` into the register by lanes: len 4 writes [31:0], len 2 writes [15:0], len 1 writes [7:0].
      - Pulse `reg_wr_stb[addr]`.
    - → IDLE.
  - Abort: in any non-IDLE state, if the active mode input (`di_read_mode` or `di_write_mode`) drops, → IDLE with no commit and no strobe.
- Read data:
  - RO register: `ro_d` lane.
  - RW register: stored value.
  - Out-of-range address: 32'h0000_0000.
  - Sampled on entry to RDY_RD and held.
- Registers reset to 0. RO lanes of `reg_q` are 0.

## Timing
- Reset values of all outputs: `di_read_rdy`=0, `di_write_rdy`=0, `di_reg_datao`=0, `di_transfer_status`=0, `reg_q`=0, `reg_wr_stb`=0, `reg_rd_stb`=0. State is IDLE.
- Request captured at edge N. Ready is asserted from edge N+1+WAIT_STATES. With WAIT_STATES=0, ready is high the cycle after the request.
- Status is valid whenever ready is high. It stays stable until ready falls, because the initiator samples it in its `di_read`/`di_write` cycle.
- Ready deasserts at the edge after `di_read`/`di_write` is sampled.
- `reg_q` updates at that same edge; the strobe is high for the following cycle.
- A new request is accepted one cycle after return to IDLE. Back-to-back transactions need no extra gap beyond this.
- Reset asserted mid-transaction clears everything immediately. No partial write survives.

## Configuration
- `DI_REG_TERMINAL_TIMEOUT_EN` defined:
  - If RDY_RD/RDY_WR persists `TIMEOUT_CYCLES` without accept or abort, → IDLE with no commit.
  - A sticky `timeout_seen` bit appears as bit 15 of all subsequent status values.
  - The sticky bit is cleared by any successful write to register 0 or by reset.
- Not defined: ready is held indefinitely; no timeout counter is synthesized; bit 15 is always 0.

## Structure
- Package `di_pkg`: status code constants, FSM state enum, and the len-to-byte-mask function.
- Sub-module `di_wait_timer`: loadable down-counter with a done flag, shared by the wait-state and timeout counts.

## Test plan
- Read, reg 1 = 0x1234_5678, WAIT_STATES=2, `di_read_req` at cycle 0 → `di_read_rdy` at cycle 3, data 0x1234_5678, status 0x0000, `reg_rd_stb[1]` pulses after `di_read`.
- Write, len 2, data 0xAAAA_BBBB to reg 3 holding 0x1111_2222 → `reg_q` lane 3 = 0x1111_BBBB, `reg_wr_stb[3]` pulses once.
- Write to address 9 with NUM_REGS=8 → status 0x0001, no register changes, no strobes. Read of address 9 → data 0, status 0x0001.
- `di_term_addr`=0x0011 with read and write traffic → ready never asserts and all outputs stay at reset values.
- Mode dropped while ready is high → IDLE, no strobe. With the macro and TIMEOUT_CYCLES=16, an unaccepted read → IDLE after 16 cycles and the next status is 0x8000.
